fetch_queue: RTL and testbench

Instruction prefetch queue between the PC register / instruction memory and the decode stage. Each cycle it captures the current PC and the instruction word read at that address, buffers up to DEPTH pairs, and drives the PC register's next-address and enable inputs. It sits at the other end of the PC register's interface, so fetch advances only while buffer space exists. Decode-stage redirects (jumps, taken branches) flush the buffer and steer the PC.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Ring buffer of fetch entries with synchronous flush; caller guarantees no push when full
// without a pop, and no pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue driving the PC register; define FETCH_QUEUE_BYPASS_EN to let an
// empty queue forward the current fetch straight to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   im_instr,
    output logic [31:0]   pc_next,
    output logic          pc_en,
    input  logic          redirect,
    input  logic [31:0]   redirect_target,
    input  logic          deq_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [CW-1:0] count
);

    fetch_entry_t    fifo_din, fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic            bypass, bypass_take, push_ok;

    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == CW'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = fifo_empty && !redirect && !reset;
`else
        bypass = 1'b0;
`endif
        out_valid   = !reset && (!fifo_empty || bypass);
        fifo_pop    = !reset && !fifo_empty && deq_ready;
        push_ok     = !reset && !redirect && (!fifo_full || fifo_pop);
        // A bypassed fetch taken by decode this cycle never occupies a slot.
        bypass_take = bypass && deq_ready;
        fifo_push   = push_ok && !bypass_take;
        fifo_flush  = redirect && !reset;
        fifo_din    = '{pc: pc_in, instr: im_instr};

        pc_en   = !reset && (redirect || push_ok);
        pc_next = pc_in;
        if (!reset) begin
            if (redirect)     pc_next = redirect_target;
            else if (push_ok) pc_next = pc_in + PC_INCR;
        end

        out_pc    = fifo_dout.pc;
        out_instr = fifo_dout.instr;
        if (bypass) begin
            out_pc    = pc_in;
            out_instr = im_instr;
        end
        count = reset ? '0 : fifo_count;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // The PC register must present its reset value in the first cycle out of reset.
    a_reset_pc: assert property (@(posedge clk) $fell(reset) |-> pc_in == RESET_PC);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed literal checks.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_reg, ovr_pc = '0, im_rand = '0, redirect_target = '0;
    logic        use_ovr = 1'b0, im_mode = 1'b0, redirect = 1'b0, deq_ready = 1'b0;
    logic [31:0] pc_in, im_instr, pc_next, out_pc, out_instr;
    logic        pc_en, out_valid;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    assign pc_in    = use_ovr ? ovr_pc : pc_reg;
    assign im_instr = im_mode ? im_rand : pc_in;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .im_instr        (im_instr),
        .pc_next         (pc_next),
        .pc_en           (pc_en),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .deq_ready       (deq_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .count           (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the queue contents as a plain list of {pc, instr}.
    logic [63:0] mq[$];
    logic        e_valid, e_en = 1'b0, e_pop = 1'b0, e_push, e_write = 1'b0, e_flush = 1'b1;
    logic        e_byp;
    logic [31:0] e_next;
    logic [63:0] e_head, e_entry = '0;
    int          n;

    always @(negedge clk) begin
        n = mq.size();
        e_entry = {pc_in, im_instr};
        if (reset) begin
            e_valid = 1'b0; e_en = 1'b0; e_next = pc_in; e_pop = 1'b0;
            e_push = 1'b0; e_write = 1'b0; e_flush = 1'b1; n = 0; e_head = '0;
        end else begin
            e_byp   = BYP && n == 0 && !redirect;
            e_valid = n > 0 || e_byp;
            e_pop   = e_valid && deq_ready;
            e_push  = !redirect && (n < DEPTH || e_pop);
            e_write = e_push && !(e_byp && deq_ready);
            e_en    = redirect || e_push;
            e_next  = redirect ? redirect_target : (e_push ? pc_in + 32'd4 : pc_in);
            e_flush = redirect;
            e_head  = (n > 0) ? mq[0] : e_entry;
        end
        chk("count", 32'(count), 32'(n));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("pc_en", 32'(pc_en), 32'(e_en));
        chk("pc_next", pc_next, e_next);
        if (e_valid) begin
            chk("out_pc", out_pc, e_head[63:32]);
            chk("out_instr", out_instr, e_head[31:0]);
        end
    end

    always @(posedge clk) begin
        if (e_flush) mq.delete();
        else begin
            if (e_pop && mq.size() > 0) void'(mq.pop_front());
            if (e_write) mq.push_back(e_entry);
        end
        if (reset) pc_reg <= RESET_PC;
        else if (e_en) pc_reg <= e_next;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        int          thr;

        // Phase 1: continuous dequeue, instruction = PC.
        repeat (3) next_cycle();
        deq_ready = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        chk("c1_count", 32'(count), 32'd0);
        chk("c1_pc_en", 32'(pc_en), 32'd1);
        chk("c1_pc_next", pc_next, 32'h0000_3004);
        chk("c1_valid", 32'(out_valid), BYP ? 32'd1 : 32'd0);
        next_cycle();
        @(negedge clk);
        chk("c2_valid", 32'(out_valid), 32'd1);
        chk("c2_out_pc", out_pc, BYP ? 32'h0000_3004 : 32'h0000_3000);
        next_cycle();
        @(negedge clk);
        chk("c3_out_pc", out_pc, BYP ? 32'h0000_3008 : 32'h0000_3004);
        repeat (5) next_cycle();

        // Phase 2: fill from reset with decode stalled, then one dequeue pulse at full.
        reset = 1'b1;
        deq_ready = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_pc_en", 32'(pc_en), 32'd0);
        chk("full_pc_next", pc_next, 32'h0000_3010);
        next_cycle();
        deq_ready = 1'b1;
        @(negedge clk);
        chk("pulse_out_pc", out_pc, 32'h0000_3000);
        chk("pulse_pc_en", 32'(pc_en), 32'd1);
        chk("pulse_pc_next", pc_next, 32'h0000_3014);
        next_cycle();
        deq_ready = 1'b0;
        @(negedge clk);
        chk("pulse_count", 32'(count), 32'd4);
        chk("pulse_head", out_pc, 32'h0000_3004);

        // Phase 3: redirect while full and stalled.
        next_cycle();
        redirect = 1'b1;
        redirect_target = 32'h0000_3400;
        @(negedge clk);
        chk("redir_pc_en", 32'(pc_en), 32'd1);
        chk("redir_pc_next", pc_next, 32'h0000_3400);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_count", 32'(count), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("redir_count2", 32'(count), 32'd1);
        chk("redir_head", out_pc, 32'h0000_3400);

        // PC increment wraps at the top of the address space.
        next_cycle();
        use_ovr = 1'b1;
        ovr_pc = 32'hFFFF_FFFC;
        deq_ready = 1'b1;
        @(negedge clk);
        chk("wrap_pc_next", pc_next, 32'h0000_0000);
        chk("wrap_pc_en", 32'(pc_en), 32'd1);
        chk("wrap_head_instr", out_instr, 32'h0000_3400);
        next_cycle();
        use_ovr = 1'b0;

        // Random phase: varying decode throughput, redirects and occasional resets.
        im_mode = 1'b1;
        thr = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) thr = $urandom_range(1, 4);
            deq_ready = ($urandom_range(0, 4) < thr);
            redirect = ($urandom_range(0, 15) == 0);
            r = $urandom();
            redirect_target = {r[31:2], 2'b00};
            im_rand = $urandom();
            reset = ($urandom_range(0, 299) == 0);
            next_cycle();
        end
        reset = 1'b0;
        redirect = 1'b0;
        repeat (2) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
